// File: rtl/alu_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_unit
// Description : EX-stage ALU with funct decode, registered single-cycle ops and
//               an iterative signed/unsigned multiply/divide engine with HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       FuncCode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             done,
    output logic             busy,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] C_F_ADD   = 6'd32;
    localparam logic [5:0] C_F_SUB   = 6'd34;
    localparam logic [5:0] C_F_AND   = 6'd36;
    localparam logic [5:0] C_F_OR    = 6'd37;
    localparam logic [5:0] C_F_NOR   = 6'd39;
    localparam logic [5:0] C_F_SLT   = 6'd42;
    localparam logic [5:0] C_F_MFHI  = 6'd16;
    localparam logic [5:0] C_F_MFLO  = 6'd18;
    localparam logic [5:0] C_F_MULT  = 6'd24;
    localparam logic [5:0] C_F_MULTU = 6'd25;
    localparam logic [5:0] C_F_DIV   = 6'd26;
    localparam logic [5:0] C_F_DIVU  = 6'd27;
    localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               done_q, done_d;
    logic               illegal_q, illegal_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   acc_q, acc_d;     // partial product high half / remainder
    logic [WIDTH-1:0]   shf_q, shf_d;     // multiplier / dividend-then-quotient
    logic [WIDTH-1:0]   opd_q, opd_d;     // multiplicand / divisor magnitude
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               div0_q, div0_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               w_mul, w_div, w_sgn, w_ill;
    logic [WIDTH-1:0]   w_alu;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;

    always_comb begin
        w_mul = 1'b0;
        w_div = 1'b0;
        w_sgn = 1'b0;
        w_ill = 1'b0;
        w_alu = '0;
        case (ALUOp)
            2'b00: w_alu = a + b;
            2'b01: w_alu = a - b;
            2'b10: begin
                case (FuncCode)
                    C_F_ADD:   w_alu = a + b;
                    C_F_SUB:   w_alu = a - b;
                    C_F_AND:   w_alu = a & b;
                    C_F_OR:    w_alu = a | b;
                    C_F_NOR:   w_alu = ~(a | b);
                    C_F_SLT:   w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                    C_F_MFHI:  w_alu = hi_q;
                    C_F_MFLO:  w_alu = lo_q;
                    C_F_MULT:  begin w_mul = 1'b1; w_sgn = 1'b1; end
                    C_F_MULTU: w_mul = 1'b1;
                    C_F_DIV:   begin w_div = 1'b1; w_sgn = 1'b1; end
                    C_F_DIVU:  w_div = 1'b1;
                    default:   w_ill = 1'b1;
                endcase
            end
            default: w_ill = 1'b1;
        endcase
    end

    assign w_abs_a = (w_sgn && a[WIDTH-1]) ? -a : a;
    assign w_abs_b = (w_sgn && b[WIDTH-1]) ? -b : b;

    // One shift-add step: add multiplicand on LSB, then shift {carry,acc,shf} right.
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    assign w_mul_sum  = shf_q[0] ? ({1'b0, acc_q} + {1'b0, opd_q}) : {1'b0, acc_q};
    assign w_prod     = {w_mul_sum, shf_q[WIDTH-1:1]};
    assign w_prod_fix = neg_q ? -w_prod : w_prod;

    // One restoring step: bring down the next dividend bit and trial-subtract.
    logic [WIDTH:0]     w_div_cat, w_div_dif;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_rem_nx, w_quo_nx, w_rem_fix, w_quo_fix;
    assign w_div_cat = {acc_q, shf_q[WIDTH-1]};
    assign w_div_ge  = (w_div_cat >= {1'b0, opd_q});
    assign w_div_dif = w_div_cat - {1'b0, opd_q};
    assign w_rem_nx  = w_div_ge ? w_div_dif[WIDTH-1:0] : w_div_cat[WIDTH-1:0];
    assign w_quo_nx  = {shf_q[WIDTH-2:0], w_div_ge};
    assign w_rem_fix = rneg_q ? -w_rem_nx : w_rem_nx;
    assign w_quo_fix = div0_q ? {WIDTH{1'b1}} : (neg_q ? -w_quo_nx : w_quo_nx);

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        shf_d     = shf_q;
        opd_d     = opd_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        div0_d    = div0_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (w_mul || w_div) begin
                        state_d = w_mul ? MUL : DIV;
                        acc_d   = '0;
                        shf_d   = w_mul ? w_abs_b : w_abs_a;
                        opd_d   = w_mul ? w_abs_a : w_abs_b;
                        neg_d   = w_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        rneg_d  = w_sgn && a[WIDTH-1];
                        div0_d  = w_div && (b == '0);
                        cnt_d   = '0;
                    end else begin
                        result_d  = w_ill ? '0 : w_alu;
                        zero_d    = w_ill || (w_alu == '0);
                        illegal_d = w_ill;
                        done_d    = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d = w_prod[2*WIDTH-1:WIDTH];
                shf_d = w_prod[WIDTH-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_LAST_ITER) begin
                    // HI/LO take the sign-corrected product as the last bit retires,
                    // so they are already valid during the FIX/done cycle.
                    hi_d    = w_prod_fix[2*WIDTH-1:WIDTH];
                    lo_d    = w_prod_fix[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = FIX;
                end
            end
            DIV: begin
                acc_d = w_rem_nx;
                shf_d = w_quo_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_LAST_ITER) begin
                    hi_d    = w_rem_fix;
                    lo_d    = w_quo_fix;
                    done_d  = 1'b1;
                    state_d = FIX;
                end
            end
            FIX: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b1;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            shf_q     <= '0;
            opd_q     <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            div0_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_q     <= acc_d;
            shf_q     <= shf_d;
            opd_q     <= opd_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            div0_q    <= div0_d;
            cnt_q     <= cnt_d;
        end
    end

    assign result  = result_q;
    assign zero    = zero_q;
    assign done    = done_q;
    assign busy    = (state_q != IDLE);
    assign illegal = illegal_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_muldiv_unit
// Description : Directed plus randomized bench for alu_muldiv_unit against a
//               transaction-level reference model using 64-bit arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [1:0]   alu_op;
    logic [5:0]   func_code;
    logic [W-1:0] a, b;
    logic [W-1:0] result, hi, lo;
    logic         zero, done, busy, illegal;

    always #5 clk = ~clk;

    alu_muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .ALUOp    (alu_op),
        .FuncCode (func_code),
        .a        (a),
        .b        (b),
        .result   (result),
        .zero     (zero),
        .done     (done),
        .busy     (busy),
        .illegal  (illegal),
        .hi       (hi),
        .lo       (lo)
    );

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted op is evaluated whole with wide arithmetic;
    // a mult/div only needs a count of its remaining busy cycles.
    logic [W-1:0] m_result, m_hi, m_lo, pend_hi, pend_lo;
    logic         m_zero, m_done, m_ill;
    int           m_left;

    always @(posedge clk) begin : model
        logic [63:0] p;
        logic [W-1:0] r;
        longint sq, sr;
        int kind;
        if (reset) begin
            m_result <= '0; m_zero <= 1'b1; m_done <= 1'b0; m_ill <= 1'b0;
            m_hi <= '0; m_lo <= '0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            m_ill  <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 2) begin
                    m_hi <= pend_hi; m_lo <= pend_lo; m_done <= 1'b1;
                end
            end else if (start) begin
                kind = 0; r = '0; p = '0; sq = 0; sr = 0;
                case (alu_op)
                    2'b00: r = a + b;
                    2'b01: r = a - b;
                    2'b11: kind = 2;
                    default: begin
                        case (func_code)
                            6'd32: r = a + b;
                            6'd34: r = a - b;
                            6'd36: r = a & b;
                            6'd37: r = a | b;
                            6'd39: r = ~(a | b);
                            6'd42: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                            6'd16: r = m_hi;
                            6'd18: r = m_lo;
                            6'd24: begin kind = 1; p = longint'($signed(a)) * longint'($signed(b)); end
                            6'd25: begin kind = 1; p = {32'd0, a} * {32'd0, b}; end
                            6'd26: begin
                                kind = 1;
                                if (b == 0) p = {a, 32'hFFFF_FFFF};
                                else begin
                                    sq = longint'($signed(a)) / longint'($signed(b));
                                    sr = longint'($signed(a)) % longint'($signed(b));
                                    p = {sr[31:0], sq[31:0]};
                                end
                            end
                            6'd27: begin
                                kind = 1;
                                if (b == 0) p = {a, 32'hFFFF_FFFF};
                                else p = {a % b, a / b};
                            end
                            default: kind = 2;
                        endcase
                    end
                endcase
                if (kind == 1) begin
                    m_left  <= W + 1;
                    pend_hi <= p[63:32];
                    pend_lo <= p[31:0];
                end else begin
                    m_done   <= 1'b1;
                    m_ill    <= (kind == 2);
                    m_result <= (kind == 2) ? '0 : r;
                    m_zero   <= (kind == 2) || (r == 0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("result",  result,  m_result);
            chk("zero",    zero,    m_zero);
            chk("done",    done,    m_done);
            chk("busy",    busy,    m_left != 0);
            chk("illegal", illegal, m_ill);
            chk("hi",      hi,      m_hi);
            chk("lo",      lo,      m_lo);
        end
    end

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom % 8)
            0: return '0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom % 16);
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue from a negedge; returns at a negedge: the done cycle for a single-cycle
    // op, or the first idle cycle after a mult/div (or after the injected reset).
    task automatic run_op(input logic [1:0] op, input logic [5:0] fc,
                          input logic [W-1:0] av, input logic [W-1:0] bv,
                          input int poke1, input int poke2, input int rst_at,
                          output int nbusy, output int ndone, output int didx);
        int n;
        alu_op = op; func_code = fc; a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        alu_op = 2'($urandom); func_code = 6'($urandom); a = 32'($urandom); b = 32'($urandom);
        n = 0; ndone = 0; didx = -1;
        while (busy && n < 100) begin
            if (done) begin ndone++; didx = n; end
            n++;
            start = (n == poke1) || (n == poke2);
            if (start) begin alu_op = 2'b00; a = 32'd1; b = 32'd2; end
            reset = (n == rst_at);
            @(negedge clk);
        end
        reset = 1'b0;
        start = 1'b0;
        nbusy = n;
    endtask

    int nb, nd, di;

    initial begin
        reset = 1'b1; start = 1'b0; alu_op = 2'b00; func_code = '0; a = '0; b = '0;
        @(negedge clk);
        @(negedge clk);
        checking = 1'b1;
        chk("rst_result", result, 64'd0);
        chk("rst_zero", zero, 64'd1);
        chk("rst_busy", busy, 64'd0);
        chk("rst_done", done, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;

        run_op(2'b10, 6'd42, 32'hFFFF_FFFF, 32'd1, -1, -1, -1, nb, nd, di);
        chk("slt_result", result, 64'd1);
        chk("slt_zero", zero, 64'd0);
        chk("slt_done", done, 64'd1);
        @(negedge clk);
        chk("slt_done_drop", done, 64'd0);
        run_op(2'b10, 6'd34, 32'd5, 32'd5, -1, -1, -1, nb, nd, di);
        chk("sub_result", result, 64'd0);
        chk("sub_zero", zero, 64'd1);

        run_op(2'b10, 6'd24, 32'hFFFF_FFFD, 32'd7, -1, -1, -1, nb, nd, di);
        chk("mult_busy_cycles", nb, 64'd33);
        chk("mult_done_count", nd, 64'd1);
        chk("mult_done_index", di, 64'd32);
        chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(2'b10, 6'd18, 32'd0, 32'd0, -1, -1, -1, nb, nd, di);
        chk("mflo_result", result, 64'hFFFF_FFEB);

        run_op(2'b10, 6'd26, 32'hFFFF_FFF9, 32'd2, -1, -1, -1, nb, nd, di);
        chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b10, 6'd27, 32'd7, 32'd0, -1, -1, -1, nb, nd, di);
        chk("divu0_busy_cycles", nb, 64'd33);
        chk("divu0_hilo", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
        run_op(2'b10, 6'd26, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1, nb, nd, di);
        chk("div_minneg_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

        run_op(2'b10, 6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 10, -1, nb, nd, di);
        chk("multu_busy_cycles", nb, 64'd33);
        chk("multu_done_count", nd, 64'd1);
        chk("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        run_op(2'b11, 6'd32, 32'd9, 32'd9, -1, -1, -1, nb, nd, di);
        chk("ill_op_flag", {illegal, done, zero}, 64'd7);
        chk("ill_op_result", result, 64'd0);
        chk("ill_op_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);
        chk("ill_flag_drop", {illegal, done}, 64'd0);
        run_op(2'b10, 6'd0, 32'd9, 32'd9, -1, -1, -1, nb, nd, di);
        chk("ill_fn_flag", {illegal, done, zero}, 64'd7);
        chk("ill_fn_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        run_op(2'b10, 6'd26, 32'd100, 32'd3, -1, -1, 10, nb, nd, di);
        chk("abort_done_count", nd, 64'd0);
        chk("abort_state", {busy, done, zero}, 64'd1);
        chk("abort_hilo", {hi, lo}, 64'd0);
        chk("abort_result", result, 64'd0);
        run_op(2'b00, 6'd0, 32'd2, 32'd3, -1, -1, -1, nb, nd, di);
        chk("add_after_abort", result, 64'd5);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset = ($urandom % 600) == 0;
            start = ($urandom % 3) == 0;
            case ($urandom % 8)
                0: alu_op = 2'b00;
                1: alu_op = 2'b01;
                2: alu_op = 2'b11;
                default: alu_op = 2'b10;
            endcase
            if (($urandom % 10) == 0) func_code = 6'($urandom);
            else begin
                case ($urandom % 12)
                    0: func_code = 6'd32;  1: func_code = 6'd34;  2: func_code = 6'd36;
                    3: func_code = 6'd37;  4: func_code = 6'd39;  5: func_code = 6'd42;
                    6: func_code = 6'd16;  7: func_code = 6'd18;  8: func_code = 6'd24;
                    9: func_code = 6'd25; 10: func_code = 6'd26; default: func_code = 6'd27;
                endcase
            end
            a = rnd_opnd();
            b = rnd_opnd();
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
